branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Fetch-side dynamic branch predictor. It is the source of the 2-bit `bpflag` that travels down the pipeline with each instruction.
- The writeback stage resolves each branch and returns `branchpdres`. This block consumes that result to train a table of 2-bit saturating counters.
- It also counts resolved branches and mispredictions for performance monitoring.

Parameters:
- WIDTH, 32, PC width.
- ENTRIES, 64, number of counters; power of 2, at least 4. IDX = log2(ENTRIES).
- INIT, 2'b01, reset value of every counter (weakly not-taken).

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- f_pc  input  WIDTH  PC of the instruction being fetched
- f_valid  input  1  f_pc is valid this cycle
- f_stall  input  1  hold the prediction register (IF/ID stall)
- f_flush  input  1  squash the prediction register
- bpflag  output  2  registered counter value for the instruction now in decode
- bp_taken  output  1  equal to bpflag[1]
- wb_pc  input  WIDTH  PC of the instruction resolving in writeback
- wb_pdres  input  2  branch result: 00 no branch, 01 resolved not-taken, 10 resolved taken, 11 ignored
- wb_redirect  input  1  writeback redirect (branchpcwe)
- br_cnt  output  32  resolved-branch count
- mis_cnt  output  32  mispredicted-branch count

Behaviour:
- Reset (async, rst_n=0):
  - all counters go to INIT; bpflag=00; bp_taken=0; br_cnt=0; mis_cnt=0.
  - Takes effect immediately, including mid-operation; any update in the same cycle is lost.
- Lookup:
  - rd_idx = f_pc[IDX+1:2].
  - Prediction-register priority, highest first:
    1. f_flush=1: load 00.
    2. f_stall=1: hold.
    3. f_valid=1: load counter[rd_idx].
    4. otherwise: load 00.
  - Latency is one cycle: bpflag reflects the f_pc sampled at the previous edge.
- Update:
  - wr_idx = wb_pc[IDX+1:2].
  - wb_pdres=10: counter[wr_idx] increments, saturating at 11.
  - wb_pdres=01: counter[wr_idx] decrements, saturating at 00.
  - wb_pdres=00 or 11: no change.
  - The update is written at the clock edge.
- Read/write collision: rd_idx==wr_idx in the same cycle returns the pre-update value (no bypass). The new value is visible from the next cycle.
- Counter semantics:
  - 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
  - Prediction is taken when bit[1] is set.
- Statistics:
  - br_cnt increments when wb_pdres is 01 or 10.
  - mis_cnt increments when wb_pdres is 01 or 10 and wb_redirect=1.
  - A JALR redirect (wb_pdres=00) is not counted.
  - Both counters saturate at 32'hFFFFFFFF; they do not wrap.
- Stall and flush never block training; updates occur regardless of f_stall or f_flush.
- The table is flop-based with one read port and one write port. All outputs are registered.

Optional Feature:
- Macro BP_GSHARE_EN.
- When defined:
  - An IDX-bit global history register ghr (reset 0) is added.
  - rd_idx = f_pc[IDX+1:2] XOR ghr; wr_idx = wb_pc[IDX+1:2] XOR ghr. Both use the ghr value before this cycle's shift.
  - On wb_pdres=01 or 10, ghr <= {ghr[IDX-2:0], wb_pdres[1]}.
  - Output ghr_out[IDX-1:0] is exposed for debug.
- When undefined: indexing is by PC bits only, and no ghr or ghr_out exists.

Test Plan:
1. Reset then lookup: f_pc=0x100, f_valid=1 -> next cycle bpflag=01, bp_taken=0; br_cnt=0, mis_cnt=0.
2. Training: three updates wb_pc=0x100, wb_pdres=10 -> counter 01→10→11→11; lookup 0x100 gives bpflag=11. Then two updates with 01 -> lookup gives 01.
3. Collision: counter[0x40 idx]=01; same cycle f_pc=0x40 lookup and wb_pc=0x40, wb_pdres=10 -> bpflag=01; next-cycle lookup gives 10.
4. Control priority: bpflag=11 held while f_stall=1 across 3 cycles with f_pc changing; then f_flush=1 together with f_stall=1 -> bpflag=00.
5. Statistics: 5 updates (pdres 10,01,10,00,11) with wb_redirect on the first two and the 00 -> br_cnt=3, mis_cnt=2. Force br_cnt to 0xFFFFFFFF, apply another branch -> stays 0xFFFFFFFF.
6. Async reset mid-update: rst_n low between edges while wb_pdres=10 -> outputs clear immediately and the counter reads INIT after release. With BP_GSHARE_EN, ENTRIES=64: pdres 10,10,01 gives ghr=6'b000110.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Fetch/writeback port bundle for branch_predictor. With BP_GSHARE_EN defined
// the bundle also carries the global-history debug output ghr_out.
interface branch_predictor_if #(
    parameter int WIDTH = 32
`ifdef BP_GSHARE_EN
    ,
    parameter int IDX = 6
`endif
);
    logic [WIDTH-1:0] f_pc;
    logic             f_valid;
    logic             f_stall;
    logic             f_flush;
    logic [1:0]       bpflag;
    logic             bp_taken;
    logic [WIDTH-1:0] wb_pc;
    logic [1:0]       wb_pdres;
    logic             wb_redirect;
    logic [31:0]      br_cnt;
    logic [31:0]      mis_cnt;
`ifdef BP_GSHARE_EN
    logic [IDX-1:0]   ghr_out;

    modport master (
        output f_pc, f_valid, f_stall, f_flush, wb_pc, wb_pdres, wb_redirect,
        input  bpflag, bp_taken, br_cnt, mis_cnt, ghr_out
    );
    modport slave (
        input  f_pc, f_valid, f_stall, f_flush, wb_pc, wb_pdres, wb_redirect,
        output bpflag, bp_taken, br_cnt, mis_cnt, ghr_out
    );
`else
    modport master (
        output f_pc, f_valid, f_stall, f_flush, wb_pc, wb_pdres, wb_redirect,
        input  bpflag, bp_taken, br_cnt, mis_cnt
    );
    modport slave (
        input  f_pc, f_valid, f_stall, f_flush, wb_pc, wb_pdres, wb_redirect,
        output bpflag, bp_taken, br_cnt, mis_cnt
    );
`endif
endinterface

// File: rtl/branch_predictor.sv
// Fetch-side 2-bit saturating-counter branch predictor with miss statistics.
// Define BP_GSHARE_EN to XOR a global history register into both table indices.
module branch_predictor #(
    parameter int         WIDTH   = 32,
    parameter int         ENTRIES = 64,
    parameter logic [1:0] INIT    = 2'b01
) (
    input  logic              clk,
    input  logic              rst_n,
    branch_predictor_if.slave bp
);
    localparam int IDX = $clog2(ENTRIES);

    logic [1:0]     ctr_q [ENTRIES];
    logic [1:0]     ctr_d [ENTRIES];
    logic [1:0]     bpflag_q, bpflag_d;
    logic [31:0]    br_cnt_q, br_cnt_d;
    logic [31:0]    mis_cnt_q, mis_cnt_d;
    logic [IDX-1:0] rd_idx;
    logic [IDX-1:0] wr_idx;
    logic [1:0]     wr_cur;
    logic           is_branch;
`ifdef BP_GSHARE_EN
    logic [IDX-1:0] ghr_q, ghr_d;
`endif

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.f_pc[WIDTH-1:IDX+2], bp.f_pc[1:0],
                              bp.wb_pc[WIDTH-1:IDX+2], bp.wb_pc[1:0]};

    always_comb begin
`ifdef BP_GSHARE_EN
        rd_idx = bp.f_pc[IDX+1:2] ^ ghr_q;
        wr_idx = bp.wb_pc[IDX+1:2] ^ ghr_q;
`else
        rd_idx = bp.f_pc[IDX+1:2];
        wr_idx = bp.wb_pc[IDX+1:2];
`endif
        is_branch = bp.wb_pdres[1] ^ bp.wb_pdres[0];
        wr_cur    = ctr_q[wr_idx];

        ctr_d = ctr_q;
        case (bp.wb_pdres)
            2'b10: if (wr_cur != 2'b11) ctr_d[wr_idx] = wr_cur + 2'd1;
            2'b01: if (wr_cur != 2'b00) ctr_d[wr_idx] = wr_cur - 2'd1;
            default: ;
        endcase

        // Reads the pre-update table: a same-cycle collision sees the old value.
        if (bp.f_flush)      bpflag_d = 2'b00;
        else if (bp.f_stall) bpflag_d = bpflag_q;
        else if (bp.f_valid) bpflag_d = ctr_q[rd_idx];
        else                 bpflag_d = 2'b00;

        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (is_branch && br_cnt_q != 32'hFFFF_FFFF)
            br_cnt_d = br_cnt_q + 32'd1;
        if (is_branch && bp.wb_redirect && mis_cnt_q != 32'hFFFF_FFFF)
            mis_cnt_d = mis_cnt_q + 32'd1;

`ifdef BP_GSHARE_EN
        ghr_d = is_branch ? {ghr_q[IDX-2:0], bp.wb_pdres[1]} : ghr_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= INIT;
            bpflag_q  <= 2'b00;
            br_cnt_q  <= 32'd0;
            mis_cnt_q <= 32'd0;
`ifdef BP_GSHARE_EN
            ghr_q     <= '0;
`endif
        end else begin
            ctr_q     <= ctr_d;
            bpflag_q  <= bpflag_d;
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
`ifdef BP_GSHARE_EN
            ghr_q     <= ghr_d;
`endif
        end
    end

    assign bp.bpflag   = bpflag_q;
    assign bp.bp_taken = bpflag_q[1];
    assign bp.br_cnt   = br_cnt_q;
    assign bp.mis_cnt  = mis_cnt_q;
`ifdef BP_GSHARE_EN
    assign bp.ghr_out  = ghr_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized and directed bench for branch_predictor with a behavioural model
// and an expected-value queue drained by a negedge monitor.
module tb_branch_predictor;
    localparam int         WIDTH   = 32;
    localparam int         ENTRIES = 64;
    localparam int         IDX     = 6;
    localparam logic [1:0] INIT    = 2'b01;
    localparam int         EW      = 2 + 32 + 32 + IDX;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_predictor_if #(
        .WIDTH(WIDTH)
`ifdef BP_GSHARE_EN
        ,
        .IDX(IDX)
`endif
    ) bus ();

    branch_predictor #(
        .WIDTH(WIDTH),
        .ENTRIES(ENTRIES),
        .INIT(INIT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bp(bus.slave)
    );

    int total = 0;
    int bad = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;

    // Reference model: plain integers and arrays
    int          m_ctr[ENTRIES];
    int          m_pred;
    logic [31:0] m_br;
    logic [31:0] m_mis;
    int          m_ghr;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) m_ctr[i] = int'(INIT);
        m_pred = 0;
        m_br   = 32'd0;
        m_mis  = 32'd0;
        m_ghr  = 0;
    endfunction

    function automatic int table_index(logic [31:0] pc);
        int base;
        base = int'((pc / 32'd4) % 32'(ENTRIES));
`ifdef BP_GSHARE_EN
        return base ^ m_ghr;
`else
        return base;
`endif
    endfunction

    function automatic void model_step(logic [31:0] fpc, logic fv, logic fs, logic ff,
                                       logic [31:0] wpc, logic [1:0] pd, logic rd);
        int r, w;
        r = table_index(fpc);
        w = table_index(wpc);
        if (ff)      m_pred = 0;
        else if (fs) m_pred = m_pred;
        else if (fv) m_pred = m_ctr[r];
        else         m_pred = 0;
        if (pd == 2'b10 && m_ctr[w] < 3) m_ctr[w] = m_ctr[w] + 1;
        if (pd == 2'b01 && m_ctr[w] > 0) m_ctr[w] = m_ctr[w] - 1;
        if (pd == 2'b01 || pd == 2'b10) begin
            if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
            if (rd && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
            m_ghr = (m_ghr * 2 + int'(pd[1])) % ENTRIES;
        end
    endfunction

    function automatic logic [EW-1:0] model_pack();
        logic [IDX-1:0] g;
        logic [1:0]     p;
        g = IDX'(m_ghr);
        p = 2'(m_pred);
        return {g, m_mis, m_br, p};
    endfunction

    // One clock: drive inputs, advance the model, queue the post-edge expectation.
    task automatic cyc(input logic [31:0] fpc, input logic fv, input logic fs, input logic ff,
                       input logic [31:0] wpc, input logic [1:0] pd, input logic rd);
        logic [EW-1:0] e;
        bus.f_pc        = fpc;
        bus.f_valid     = fv;
        bus.f_stall     = fs;
        bus.f_flush     = ff;
        bus.wb_pc       = wpc;
        bus.wb_pdres    = pd;
        bus.wb_redirect = rd;
        model_step(fpc, fv, fs, ff, wpc, pd, rd);
        e = model_pack();
        @(posedge clk);
        exp_q.push_back(e);
        #2;
    endtask

    task automatic idle();
        cyc(32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 2'b00, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("bpflag", 64'(bus.bpflag), 64'(mon_e[1:0]));
            chk("bp_taken", 64'(bus.bp_taken), 64'(mon_e[1]));
            chk("br_cnt", 64'(bus.br_cnt), 64'(mon_e[33:2]));
            chk("mis_cnt", 64'(bus.mis_cnt), 64'(mon_e[65:34]));
`ifdef BP_GSHARE_EN
            chk("ghr_out", 64'(bus.ghr_out), 64'(mon_e[EW-1:66]));
`endif
        end
    end

    initial begin
        logic [31:0] br0;
        logic [31:0] mis0;
        bus.f_pc = '0; bus.f_valid = 1'b0; bus.f_stall = 1'b0; bus.f_flush = 1'b0;
        bus.wb_pc = '0; bus.wb_pdres = 2'b00; bus.wb_redirect = 1'b0;
        model_reset();
        #3;
        chk("rst_bpflag", 64'(bus.bpflag), 64'd0);
        chk("rst_br_cnt", 64'(bus.br_cnt), 64'd0);
        chk("rst_mis_cnt", 64'(bus.mis_cnt), 64'd0);
        #9 rst_n = 1'b1;

        // Reset then lookup
        cyc(32'h100, 1'b1, 1'b0, 1'b0, 32'd0, 2'b00, 1'b0);
        chk("first_lookup", 64'(bus.bpflag), 64'(INIT));
        chk("first_taken", 64'(bus.bp_taken), 64'd0);

        // Collision: same-cycle read of the entry being trained returns the old value
        cyc(32'h40, 1'b1, 1'b0, 1'b0, 32'h40, 2'b10, 1'b0);
        chk("collision_old", 64'(bus.bpflag), 64'(INIT));
        cyc(32'h40, 1'b1, 1'b0, 1'b0, 32'd0, 2'b00, 1'b0);

        // Training up to saturation then back down
        repeat (3) cyc(32'd0, 1'b0, 1'b0, 1'b0, 32'h100, 2'b10, 1'b0);
        cyc(32'h100, 1'b1, 1'b0, 1'b0, 32'd0, 2'b00, 1'b0);
        repeat (2) cyc(32'd0, 1'b0, 1'b0, 1'b0, 32'h100, 2'b01, 1'b0);
        cyc(32'h100, 1'b1, 1'b0, 1'b0, 32'd0, 2'b00, 1'b0);

        // Stall holds, flush beats stall
        repeat (3) cyc(32'd0, 1'b0, 1'b0, 1'b0, 32'h100, 2'b10, 1'b0);
        cyc(32'h100, 1'b1, 1'b0, 1'b0, 32'd0, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc(32'(i * 4 + 8), 1'b1, 1'b1, 1'b0, 32'd0, 2'b00, 1'b0);
        cyc(32'h100, 1'b1, 1'b1, 1'b1, 32'd0, 2'b00, 1'b0);
        chk("flush_over_stall", 64'(bus.bpflag), 64'd0);

        // Statistics
        br0  = m_br;
        mis0 = m_mis;
        cyc(32'd0, 1'b0, 1'b0, 1'b0, 32'h200, 2'b10, 1'b1);
        cyc(32'd0, 1'b0, 1'b0, 1'b0, 32'h204, 2'b01, 1'b1);
        cyc(32'd0, 1'b0, 1'b0, 1'b0, 32'h208, 2'b10, 1'b0);
        cyc(32'd0, 1'b0, 1'b0, 1'b0, 32'h20c, 2'b00, 1'b1);
        cyc(32'd0, 1'b0, 1'b0, 1'b0, 32'h210, 2'b11, 1'b0);
        chk("stats_br", 64'(bus.br_cnt), 64'(br0 + 32'd3));
        chk("stats_mis", 64'(bus.mis_cnt), 64'(mis0 + 32'd2));

        // Saturation of the branch counter
        #5;
        force dut.br_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.br_cnt_q;
        m_br = 32'hFFFF_FFFF;
        cyc(32'd0, 1'b0, 1'b0, 1'b0, 32'h300, 2'b10, 1'b1);
        chk("br_saturate", 64'(bus.br_cnt), 64'hFFFF_FFFF);
        cyc(32'd0, 1'b0, 1'b0, 1'b0, 32'h300, 2'b01, 1'b0);

        // Async reset between edges with an update pending
        bus.f_pc = 32'h100; bus.f_valid = 1'b1;
        bus.wb_pc = 32'h100; bus.wb_pdres = 2'b10; bus.wb_redirect = 1'b1;
        #5;
        rst_n = 1'b0;
        #1;
        chk("async_bpflag", 64'(bus.bpflag), 64'd0);
        chk("async_taken", 64'(bus.bp_taken), 64'd0);
        chk("async_br", 64'(bus.br_cnt), 64'd0);
        chk("async_mis", 64'(bus.mis_cnt), 64'd0);
        model_reset();
        exp_q.delete();
        bus.f_valid = 1'b0; bus.wb_pdres = 2'b00; bus.wb_redirect = 1'b0;
        #1 rst_n = 1'b1;
        idle();
        cyc(32'h100, 1'b1, 1'b0, 1'b0, 32'd0, 2'b00, 1'b0);
        chk("post_reset_lookup", 64'(bus.bpflag), 64'(INIT));

        // History shift: 10, 10, 01
        cyc(32'd0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b10, 1'b0);
        cyc(32'd0, 1'b0, 1'b0, 1'b0, 32'h4, 2'b10, 1'b0);
        cyc(32'd0, 1'b0, 1'b0, 1'b0, 32'h8, 2'b01, 1'b0);
`ifdef BP_GSHARE_EN
        chk("ghr_pattern", 64'(bus.ghr_out), 64'(6'b000110));
`endif

        // Randomized traffic
        repeat (400) begin
            cyc({22'd0, 8'($urandom_range(0, 255)), 2'b00},
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 5) == 0,
                $urandom_range(0, 9) == 0,
                {22'd0, 8'($urandom_range(0, 255)), 2'b00},
                2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
